clockdiv_multi: RTL

CLOCKDIV_MULTI -- requirements
Module: clockdiv_multi

---
 rtl/clockdiv_pkg.sv | 10 +
 rtl/clockdiv_chan.sv | 63 ++++++
 rtl/clockdiv_multi.sv | 55 +++++
 3 files changed

// File: rtl/clockdiv_pkg.sv
// Shared defaults and types for the multi-channel clock divider.
package clockdiv_pkg;
    localparam int CNT_W_DEF        = 16;
    localparam int DEFAULT_HALF_DEF = 20000;

    typedef struct packed {
        logic [CNT_W_DEF-1:0] half;
        logic                 pending;
    } chan_cfg_t;
endpackage

// File: rtl/clockdiv_chan.sv
// One divider channel: active/shadow half-period, counter and registered outputs.
import clockdiv_pkg::*;

module clockdiv_chan #(
    parameter int CNT_W        = CNT_W_DEF,
    parameter int DEFAULT_HALF = DEFAULT_HALF_DEF
) (
    input  logic             clk_in,
    input  logic             reset,
    input  logic             enable,
    input  logic             resync,
    input  logic             wr_en,
    input  logic [CNT_W-1:0] wr_half,
    output logic             pending,
    output logic             clk_out,
    output logic             tick
);
    localparam logic [CNT_W-1:0] HALF_RST = CNT_W'(DEFAULT_HALF);

    logic [CNT_W-1:0] half_act;
    logic [CNT_W-1:0] half_shd;
    logic [CNT_W-1:0] cnt;
    logic             boundary;

    assign boundary = (cnt == half_act - 1'b1);

    always_ff @(posedge clk_in) begin
        if (reset) begin
            half_act <= HALF_RST;
            half_shd <= HALF_RST;
            pending  <= 1'b0;
            cnt      <= '0;
            clk_out  <= 1'b0;
            tick     <= 1'b0;
        end else begin
            // wr_en is only raised while pending is clear, so it never races the apply below
            if (wr_en) begin
                half_shd <= wr_half;
                pending  <= 1'b1;
            end
            if (resync || !enable) begin
                cnt     <= '0;
                clk_out <= 1'b0;
                tick    <= 1'b0;
                if (pending) begin
                    half_act <= half_shd;
                    pending  <= 1'b0;
                end
            end else if (boundary) begin
                cnt     <= '0;
                clk_out <= ~clk_out;
                tick    <= ~clk_out;
                if (pending) begin
                    half_act <= half_shd;
                    pending  <= 1'b0;
                end
            end else begin
                cnt  <= cnt + 1'b1;
                tick <= 1'b0;
            end
        end
    end
endmodule

// File: rtl/clockdiv_multi.sv
// Multi-channel clock divider: config decode, cfg_ready mux and channel array.
import clockdiv_pkg::*;

module clockdiv_multi #(
    parameter int  NUM_CH       = 4,
    parameter int  CNT_W        = CNT_W_DEF,
    parameter int  DEFAULT_HALF = DEFAULT_HALF_DEF,
    localparam int CH_W         = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk_in,
    input  logic              reset,
    input  logic [NUM_CH-1:0] enable,
    input  logic              resync,
    input  logic              cfg_valid,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [CNT_W-1:0]  cfg_half,
    output logic              cfg_ready,
    output logic [NUM_CH-1:0] clk_out,
    output logic [NUM_CH-1:0] tick
);
    logic [NUM_CH-1:0] pend;
    logic [NUM_CH-1:0] wr_en;
    logic [CNT_W-1:0]  half_w;

    // Unmatched channel numbers leave cfg_ready low and no channel written
    always_comb begin
        cfg_ready = 1'b0;
        wr_en     = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (cfg_ch == CH_W'(i)) begin
                cfg_ready = ~pend[i];
                wr_en[i]  = cfg_valid & ~pend[i];
            end
        end
    end

    assign half_w = (cfg_half == '0) ? CNT_W'(1) : cfg_half;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_chan
        clockdiv_chan #(
            .CNT_W        (CNT_W),
            .DEFAULT_HALF (DEFAULT_HALF)
        ) u_chan (
            .clk_in  (clk_in),
            .reset   (reset),
            .enable  (enable[g]),
            .resync  (resync),
            .wr_en   (wr_en[g]),
            .wr_half (half_w),
            .pending (pend[g]),
            .clk_out (clk_out[g]),
            .tick    (tick[g])
        );
    end
endmodule
